data_memory_ctrl: RTL and testbench
===================================

// Module: data_memory_ctrl
// PURPOSE
//  Parametrised, byte-addressed data memory for the RISC-V core. Successor to the flat word RAM.
//  Adds RISC-V load/store sizes (LB/LH/LW/LBU/LHU, SB/SH/SW), byte-lane write masking and
//  sign/zero extension. Adds misalignment, range and illegal-funct3 faults.
//  Adds configurable access latency behind a valid/ready request and a 1-cycle response pulse.
//  Sits between the datapath's ALU address/rs2 and the writeback mux.
// PARAMETERS
//  DEPTH_WORDS  1024  number of 32-bit words; byte address space is DEPTH_WORDS*4
//  ADDR_W       32    request address width (byte address)
//  WAIT_STATES  0     extra cycles between accept and access (0..15)
//  INIT_FILE    ""    if non-empty, $readmemh into the array at time 0
// PORTS
//  clk        in   1       rising-edge clock
//  rst_n      in   1       asynchronous active-low reset
//  req_valid  in   1       request present
//  req_ready  out  1       block can accept; high only in IDLE
//  req_we     in   1       1 = store, 0 = load
//  req_funct3 in   3       RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  req_addr   in   ADDR_W  byte address
//  req_wdata  in   32      store data, LSB-justified (rs2)
//  rsp_valid  out  1       one-cycle pulse: access complete
//  rsp_rdata  out  32      extended load data; 0 for stores and faults
//  rsp_fault  out  1       valid with rsp_valid: request rejected, no side effect
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_fault=0.
//   Array contents are not cleared.
//  FSM IDLE -> WAIT -> ACCESS -> IDLE. WAIT is skipped when WAIT_STATES=0.
//  IDLE: req_ready=1. On req_valid: capture we/funct3/addr/wdata, load cnt=WAIT_STATES, go to WAIT.
//   If WAIT_STATES=0, go directly to ACCESS.
//  WAIT: cnt decrements each cycle; at cnt==1 go to ACCESS. req_ready=0.
//  ACCESS (one cycle): on the edge leaving ACCESS:
//   - perform the masked write, or register the extended load;
//   - set rsp_valid=1 for exactly one cycle;
//   - return to IDLE.
//   rsp_valid therefore rises WAIT_STATES+1 cycles after acceptance.
//  A new request may be accepted in the same cycle rsp_valid is high (IDLE is already re-entered).
//  Fault, evaluated on the captured request:
//   - H/HU with addr[0]!=0, or W with addr[1:0]!=0;
//   - addr >= DEPTH_WORDS*4;
//   - load funct3 in {011,110,111};
//   - store funct3 > 010.
//   On fault: rsp_fault=1, rsp_rdata=0, no array write.
//  Word index = addr[2 +: log2(DEPTH_WORDS)]. Byte lane = addr[1:0].
//  Store byte enables: SB = 1<<lane; SH = 0011<<lane; SW = 1111.
//   Write data is replicated per lane: SB {4{b}}, SH {2{h}}.
//  Load: word >> (8*lane), then
//   - LB/LH sign-extend from bit 7/15;
//   - LBU/LHU zero-extend;
//   - LW passes through.
//  Load and store are never in flight together (single outstanding request), so no read/write hazard.
//  rsp_rdata/rsp_fault hold their values until the next ACCESS; only rsp_valid qualifies them.
//  Reset mid-operation: the pending request is dropped.
//   A store whose ACCESS edge has not occurred is not written. No rsp_valid is produced.
//  req_* inputs are ignored while req_ready=0.
// STRUCTURE
//  Shared package mem_pkg:
//   - funct3 localparams F3_B/F3_H/F3_W/F3_BU/F3_HU;
//   - state encoding ST_IDLE/ST_WAIT/ST_ACCESS.
//  Sub-module lsu_lane_align (combinational):
//   - inputs funct3, addr[1:0], wdata, rword;
//   - outputs be[3:0], wdata_rep[31:0], rdata_ext[31:0], misaligned.
//  Top holds the FSM, wait counter, capture registers, fault logic and the reg [31:0] array
//   with a per-byte write.
// TESTING
//  1 Reset mid-WAIT (WAIT_STATES=3): accept SW at cycle 1, pull rst_n low at cycle 2 ->
//    no rsp_valid; a later LW of the same address returns the old contents.
//  2 WAIT_STATES=0: SW 0x0000_0080 <- 0xDEADBEEF, then LW 0x80 ->
//    rsp_valid 1 cycle after each accept; rdata=0xDEADBEEF.
//  3 Byte lanes: SB 0x83 <- 0x12 over 0xDEADBEEF; LW 0x80 -> 0x12ADBEEF.
//    Then LB 0x83 -> 0x00000012, LH 0x82 -> 0x000012AD.
//  4 Extension: SW 0x90 <- 0x0000_80F0.
//    LB 0x90 -> 0xFFFFFFF0; LBU 0x90 -> 0x000000F0; LH 0x90 -> 0xFFFF80F0; LHU 0x90 -> 0x000080F0.
//  5 Faults:
//    - LW 0x82, SH 0x81, load funct3=011, SW at DEPTH_WORDS*4 -> each rsp_fault=1, rdata=0;
//    - a follow-up LW of the targeted words shows them unchanged.
//  6 Latency/back-to-back (WAIT_STATES=3): req_valid held high ->
//    req_ready low for 4 cycles after each accept; rsp_valid 4 cycles after accept;
//    next accept in the rsp_valid cycle.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings for the RISC-V data memory controller:
// load/store size codes (funct3) and controller state encoding.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for RISC-V loads/stores: store byte enables and data
// replication, load shift plus sign/zero extension, and alignment check.
module lsu_lane_align
  import mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext,
  output logic        misaligned
);

  logic [31:0] shifted;

  assign shifted = rword >> {lane, 3'b000};

  always_comb begin
    be         = 4'b0000;
    wdata_rep  = wdata;
    rdata_ext  = 32'h0;
    misaligned = 1'b0;
    case (funct3)
      F3_B: begin
        be        = 4'b0001 << lane;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = {{24{shifted[7]}}, shifted[7:0]};
      end
      F3_BU: begin
        rdata_ext = {24'h0, shifted[7:0]};
      end
      F3_H: begin
        be         = 4'b0011 << lane;
        wdata_rep  = {2{wdata[15:0]}};
        rdata_ext  = {{16{shifted[15]}}, shifted[15:0]};
        misaligned = lane[0];
      end
      F3_HU: begin
        rdata_ext  = {16'h0, shifted[15:0]};
        misaligned = lane[0];
      end
      F3_W: begin
        be         = 4'b1111;
        rdata_ext  = shifted;
        misaligned = |lane;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/data_memory_ctrl.sv
// Byte-addressed data memory with RISC-V load/store sizes, fault detection,
// configurable wait states and a single-cycle response pulse.
module data_memory_ctrl
  import mem_pkg::*;
#(
  parameter int    DEPTH_WORDS = 1024,
  parameter int    ADDR_W      = 32,
  parameter int    WAIT_STATES = 0,
  parameter string INIT_FILE   = ""
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_fault
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_W:0] BYTE_LIMIT = (ADDR_W+1)'(longint'(DEPTH_WORDS) * 4);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q;
  logic              accept;

  logic              we_p1;
  logic [2:0]        funct3_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic [31:0]       wdata_p1;

  logic [31:0]       mem [DEPTH_WORDS];
  logic [IDX_W-1:0]  widx;
  logic [31:0]       rword;
  logic [3:0]        be;
  logic [31:0]       wdata_rep;
  logic [31:0]       rdata_ext;
  logic              misaligned;
  logic              out_of_range;
  logic              bad_funct3;
  logic              fault;
  logic              do_write;

  assign accept = req_valid && req_ready;

  // ---- stage p0 -> p1: request capture in IDLE
  always_ff @(posedge clk) begin
    if (accept) begin
      we_p1     <= req_we;
      funct3_p1 <= req_funct3;
      addr_p1   <= req_addr;
      wdata_p1  <= req_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      if (accept)
        cnt_q <= 4'(WAIT_STATES);
      else if (state_q == ST_WAIT)
        cnt_q <= cnt_q - 4'd1;
    end
  end

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid)
          state_d = (WAIT_STATES == 0) ? ST_ACCESS : ST_WAIT;
      end
      // The <= 1 guard keeps a corrupted count from stalling forever.
      ST_WAIT: begin
        if (cnt_q <= 4'd1)
          state_d = ST_ACCESS;
      end
      ST_ACCESS: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // ---- stage p1: lane steering and fault evaluation on the captured request
  assign widx  = addr_p1[2 +: IDX_W];
  assign rword = mem[widx];

  lsu_lane_align u_align (
    .funct3     (funct3_p1),
    .lane       (addr_p1[1:0]),
    .wdata      (wdata_p1),
    .rword      (rword),
    .be         (be),
    .wdata_rep  (wdata_rep),
    .rdata_ext  (rdata_ext),
    .misaligned (misaligned)
  );

  assign out_of_range = {1'b0, addr_p1} >= BYTE_LIMIT;
  assign bad_funct3   = we_p1 ? (funct3_p1 > F3_W)
                              : (funct3_p1 inside {3'b011, 3'b110, 3'b111});
  assign fault        = misaligned || out_of_range || bad_funct3;
  assign do_write     = (state_q == ST_ACCESS) && we_p1 && !fault;

  // ---- stage p1 -> p2: array write and response register on the ACCESS edge
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b])
          mem[widx][8*b +: 8] <= wdata_rep[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_fault <= 1'b0;
    end else begin
      rsp_valid <= (state_q == ST_ACCESS);
      if (state_q == ST_ACCESS) begin
        rsp_fault <= fault;
        rsp_rdata <= (fault || we_p1) ? 32'h0 : rdata_ext;
      end
    end
  end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench: a zero-wait instance for data-path vectors and a
// three-wait-state instance for latency, back-to-back and reset cases.
module tb_data_memory_ctrl;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_we     [2];
  logic [2:0]  req_funct3 [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic        rsp_valid  [2];
  logic [31:0] rsp_rdata  [2];
  logic        rsp_fault  [2];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  data_memory_ctrl #(.DEPTH_WORDS(64), .ADDR_W(32), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_funct3(req_funct3[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_fault(rsp_fault[0])
  );

  data_memory_ctrl #(.DEPTH_WORDS(64), .ADDR_W(32), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_funct3(req_funct3[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_fault(rsp_fault[1])
  );

  typedef struct {
    string       name;
    bit          we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    bit          exp_flt;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic do_req(input int s, input bit we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic flt, output int lat);
    int n;
    n = 0;
    while (!req_ready[s] && n < 20) begin
      @(posedge clk); #1; n++;
    end
    req_valid[s] = 1'b1; req_we[s] = we; req_funct3[s] = f3;
    req_addr[s] = a; req_wdata[s] = wd;
    @(posedge clk); #1;
    req_valid[s] = 1'b0;
    lat = 0;
    while (!rsp_valid[s] && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    rd  = rsp_rdata[s];
    flt = rsp_fault[s];
  endtask

  function automatic vec_t mk(input string nm, input bit we, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] er, input bit ef);
    vec_t v;
    v.name = nm; v.we = we; v.f3 = f3; v.addr = a; v.wdata = wd;
    v.exp_rd = er; v.exp_flt = ef;
    return v;
  endfunction

  initial begin
    logic [31:0] rd;
    logic        flt;
    int          lat;
    bit          seen;

    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0; req_we[i] = 1'b0; req_funct3[i] = 3'b0;
      req_addr[i] = 32'h0; req_wdata[i] = 32'h0;
    end

    vecs.push_back(mk("sw_0x00",      1, F3_W,   32'h00, 32'hA5A5A5A5, 32'h0, 0));
    vecs.push_back(mk("sw_0x80",      1, F3_W,   32'h80, 32'hDEADBEEF, 32'h0, 0));
    vecs.push_back(mk("lw_0x80",      0, F3_W,   32'h80, 32'h0, 32'hDEADBEEF, 0));
    vecs.push_back(mk("sb_0x83",      1, F3_B,   32'h83, 32'h00000012, 32'h0, 0));
    vecs.push_back(mk("lw_after_sb",  0, F3_W,   32'h80, 32'h0, 32'h12ADBEEF, 0));
    vecs.push_back(mk("lb_0x83",      0, F3_B,   32'h83, 32'h0, 32'h00000012, 0));
    vecs.push_back(mk("lh_0x82",      0, F3_H,   32'h82, 32'h0, 32'h000012AD, 0));
    vecs.push_back(mk("sw_0x90",      1, F3_W,   32'h90, 32'h000080F0, 32'h0, 0));
    vecs.push_back(mk("lb_0x90",      0, F3_B,   32'h90, 32'h0, 32'hFFFFFFF0, 0));
    vecs.push_back(mk("lbu_0x90",     0, F3_BU,  32'h90, 32'h0, 32'h000000F0, 0));
    vecs.push_back(mk("lh_0x90",      0, F3_H,   32'h90, 32'h0, 32'hFFFF80F0, 0));
    vecs.push_back(mk("lhu_0x90",     0, F3_HU,  32'h90, 32'h0, 32'h000080F0, 0));
    vecs.push_back(mk("flt_lw_0x82",  0, F3_W,   32'h82, 32'h0, 32'h0, 1));
    vecs.push_back(mk("flt_sh_0x81",  1, F3_H,   32'h81, 32'h0000FFFF, 32'h0, 1));
    vecs.push_back(mk("flt_ld_f3_3",  0, 3'b011, 32'h80, 32'h0, 32'h0, 1));
    vecs.push_back(mk("flt_sw_range", 1, F3_W,   32'h100, 32'h11111111, 32'h0, 1));
    vecs.push_back(mk("flt_st_f3_3",  1, 3'b011, 32'h90, 32'hFFFFFFFF, 32'h0, 1));
    vecs.push_back(mk("lw_80_intact", 0, F3_W,   32'h80, 32'h0, 32'h12ADBEEF, 0));
    vecs.push_back(mk("lw_90_intact", 0, F3_W,   32'h90, 32'h0, 32'h000080F0, 0));
    vecs.push_back(mk("lw_00_intact", 0, F3_W,   32'h00, 32'h0, 32'hA5A5A5A5, 0));
    vecs.push_back(mk("sh_0x92",      1, F3_H,   32'h92, 32'hFFFF1234, 32'h0, 0));
    vecs.push_back(mk("lw_after_sh",  0, F3_W,   32'h90, 32'h0, 32'h123480F0, 0));

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_req_ready", 32'(req_ready[i]), 32'd1);
      chk("rst_rsp_valid", 32'(rsp_valid[i]), 32'd0);
      chk("rst_rsp_rdata", rsp_rdata[i], 32'h0);
      chk("rst_rsp_fault", 32'(rsp_fault[i]), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Reset mid-WAIT drops a pending store
    do_req(1, 1, F3_W, 32'h40, 32'h11112222, rd, flt, lat);
    chk("ws3_sw_lat", 32'(lat), 32'd4);
    chk("ws3_sw_fault", 32'(flt), 32'd0);
    req_valid[1] = 1'b1; req_we[1] = 1'b1; req_funct3[1] = F3_W;
    req_addr[1] = 32'h40; req_wdata[1] = 32'h99999999;
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    chk("midrst_accepted", 32'(req_ready[1]), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", 32'(req_ready[1]), 32'd1);
    chk("midrst_valid", 32'(rsp_valid[1]), 32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (rsp_valid[1]) seen = 1'b1;
    end
    chk("midrst_no_rsp", 32'(seen), 32'd0);
    do_req(1, 0, F3_W, 32'h40, 32'h0, rd, flt, lat);
    chk("midrst_old_data", rd, 32'h11112222);
    chk("midrst_lw_lat", 32'(lat), 32'd4);

    // Zero-wait-state vector table
    for (int i = 0; i < vecs.size(); i++) begin
      do_req(0, vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, rd, flt, lat);
      chk({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rd);
      chk({vecs[i].name, "_fault"}, 32'(flt), 32'(vecs[i].exp_flt));
      chk({vecs[i].name, "_lat"}, 32'(lat), 32'd1);
    end

    // Back-to-back with req_valid held high, WAIT_STATES=3
    req_valid[1] = 1'b1; req_we[1] = 1'b1; req_funct3[1] = F3_W;
    req_addr[1] = 32'h44; req_wdata[1] = 32'h00000055;
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      chk("b2b_st_ready_low", 32'(req_ready[1]), 32'd0);
      chk("b2b_st_no_rsp", 32'(rsp_valid[1]), 32'd0);
      @(posedge clk); #1;
    end
    chk("b2b_st_rsp", 32'(rsp_valid[1]), 32'd1);
    chk("b2b_st_ready_in_rsp", 32'(req_ready[1]), 32'd1);
    req_we[1] = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      chk("b2b_ld_ready_low", 32'(req_ready[1]), 32'd0);
      chk("b2b_ld_no_rsp", 32'(rsp_valid[1]), 32'd0);
      @(posedge clk); #1;
    end
    chk("b2b_ld_rsp", 32'(rsp_valid[1]), 32'd1);
    chk("b2b_ld_rdata", rsp_rdata[1], 32'h00000055);
    req_valid[1] = 1'b0;
    @(posedge clk); #1;
    chk("b2b_idle_ready", 32'(req_ready[1]), 32'd1);
    chk("b2b_single_pulse", 32'(rsp_valid[1]), 32'd0);
    chk("b2b_rdata_hold", rsp_rdata[1], 32'h00000055);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
